logic_unit_arbiter: RTL
=======================

# logic_unit_arbiter

Shares one 2-bit bitwise logic unit (AND/OR/XOR/NAND) between NUM_REQ requesters. Arbitrates with a round-robin pointer, accepts at most one operation per cycle over a valid/ready handshake, and holds the result in a single registered output stage with backpressure. It sits between the per-channel bitwise gates and the response consumer, so the design needs one gate instance instead of one per channel.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- WIDTH, 2: operand and result width
- ID_W, 2: requester index width; must equal clog2(NUM_REQ)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high
- req_a  in  NUM_REQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing as req_a
- req_op  in  NUM_REQ*2  opcode per requester: 00 AND, 01 OR, 10 XOR, 11 NAND
- rsp_valid  out  1  result held in the output stage
- rsp_ready  in  1  consumer accepts the result
- rsp_data  out  WIDTH  result
- rsp_id  out  ID_W  index of the requester that owns rsp_data
- busy  out  1  equals rsp_valid, for status and debug

## Operation
- Output stage FSM has two states:
  - EMPTY (rsp_valid=0)
  - FULL (rsp_valid=1)
- can_accept = EMPTY, or FULL with rsp_ready=1.
- Grant selection (combinational):
  - Scan requesters starting at (last_grant+1) mod NUM_REQ.
  - The first index with req_valid=1 wins.
  - req_ready[winner] = can_accept; all other req_ready bits are 0.
- Accept happens when req_valid[i] and req_ready[i] are both 1 at a rising edge. On accept:
  - rsp_data <= op(a_i, b_i)
  - rsp_id <= i
  - last_grant <= i
  - state moves to FULL
- Transitions:
  - EMPTY with accept goes to FULL.
  - FULL with rsp_ready and accept stays FULL and loads the new result (back-to-back, no bubble).
  - FULL with rsp_ready and no accept goes to EMPTY.
  - FULL without rsp_ready holds; rsp_data and rsp_id stay stable.
- last_grant changes only on accept, so a stalled output does not rotate priority.
- With no req_valid set, no req_ready is raised and the pointer is unchanged.
- Ops are bitwise on WIDTH bits with no carry. NAND is ~(a&b) truncated to WIDTH.
- Requesters must hold req_valid, operands and opcode stable until accepted. Dropping req_valid early is permitted; that request is then simply not accepted.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, last_grant=NUM_REQ-1 (requester 0 has first priority).
- req_ready is 0 during reset.
- Latency: accepted at edge T, rsp_valid=1 and the result visible after edge T, i.e. in cycle T+1.
- Throughput: one operation per cycle while rsp_ready is held at 1.
- Fairness: with all requesters valid continuously, grants rotate 0,1,…,NUM_REQ-1,0…; each requester waits at most NUM_REQ-1 accepts.
- rst asserted mid-operation discards any held result at the next edge. A request presented in the same cycle as reset is not accepted.
- When a result is drained and a new request arrives in the same cycle, the new request is accepted and the drained result is not duplicated.

## Configuration
- LOGIC_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, lowest index wins. last_grant is not implemented and the scan always starts at 0.
  - Undefined (default): round-robin as described in Operation.
- Ports and latency are identical in both builds.

## Structure
- Shared include file logic_unit_defs.vh holds:
  - opcode constants OP_AND, OP_OR, OP_XOR, OP_NAND
  - default WIDTH and NUM_REQ
- Sub-module bitwise_unit is purely combinational: a, b, op in; y out. It is instantiated once, fed by the winner's operand mux.
- The arbiter keeps the grant scan, the pointer and the output register.

## Test plan
- Reset, then requester 0 only: a=01, b=01, op=AND → req_ready[0]=1; next cycle rsp_valid=1, rsp_data=01, rsp_id=0.
- All four requesters valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0, with rsp_valid high every cycle.
- Stall: result held, rsp_ready=0 for 3 cycles with requests pending → all req_ready=0; rsp_data and rsp_id stable; pointer unchanged.
- Opcode sweep on one requester with a=10, b=11: AND→10, OR→11, XOR→01, NAND→01.
- rst pulsed while FULL with requests pending → next cycle rsp_valid=0 and requester 0 is granted first.
- With LOGIC_ARB_FIXED_PRIO_EN defined, requesters 1 and 3 continuously valid → rsp_id always 1.

Source files
------------

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic-unit arbiter: opcode encodings, default
// sizing and the output-stage state encoding.
package logic_unit_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_WIDTH   = 2;
  localparam int unsigned OP_W        = 2;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/logic_unit_arbiter_bitwise_unit.sv
// Purely combinational bitwise logic unit shared by all requesters.
// Ports: a, b operands; op opcode (AND/OR/XOR/NAND); y_c result.
module logic_unit_arbiter_bitwise_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y_c
);

  // Bitwise, no carry; NAND stays WIDTH bits wide.
  always_comb begin
    y_c = '0;
    case (op)
      OP_AND:  y_c = a & b;
      OP_OR:   y_c = a | b;
      OP_XOR:  y_c = a ^ b;
      OP_NAND: y_c = ~(a & b);
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one bitwise logic unit between NUM_REQ requesters using a
// round-robin grant and a single registered output stage with backpressure.
// Build option: LOGIC_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// and removes the round-robin pointer.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_valid      per-requester valid
//   req_ready      per-requester accept (one-hot or zero, combinational)
//   req_a, req_b   packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op         packed 2-bit opcodes, requester i at [i*2 +: 2]
//   rsp_valid      result held in output stage
//   rsp_ready      consumer accepts result
//   rsp_data       result
//   rsp_id         owner of rsp_data
//   busy           mirrors rsp_valid
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*WIDTH-1:0]  req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WIDTH-1:0]          rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);

  state_e            state;
  logic [ID_W-1:0]   start_c;
  logic [ID_W-1:0]   win_c;
  logic              found_c;
  logic              can_accept_c;
  logic              accept_c;
  logic [WIDTH-1:0]  y_c;

  logic [WIDTH-1:0]  a_arr  [NUM_REQ];
  logic [WIDTH-1:0]  b_arr  [NUM_REQ];
  logic [OP_W-1:0]   op_arr [NUM_REQ];

  // Unpack per-requester payload fields.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i]  = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i]  = req_b[i*WIDTH +: WIDTH];
    assign op_arr[i] = req_op[i*OP_W +: OP_W];
  end

`ifdef LOGIC_ARB_FIXED_PRIO_EN
  assign start_c = '0;
`else
  logic [ID_W-1:0] last_grant;

  // Scan begins one past the last winner, wrapping at NUM_REQ.
  assign start_c = (last_grant == ID_W'(NUM_REQ - 1)) ? '0 : last_grant + ID_W'(1);
`endif

  // First valid requester at or after start_c wins.
  always_comb begin
    int idx;
    found_c = 1'b0;
    win_c   = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = int'(start_c) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (!found_c && req_valid[ID_W'(idx)]) begin
        found_c = 1'b1;
        win_c   = ID_W'(idx);
      end
    end
  end

  assign can_accept_c = (state == ST_EMPTY) || rsp_ready;
  assign accept_c     = found_c && can_accept_c && !rst;

  // Only the winner sees ready, and only when the output stage can take it.
  always_comb begin
    req_ready = '0;
    if (accept_c) req_ready[win_c] = 1'b1;
  end

  logic_unit_arbiter_bitwise_unit #(
    .WIDTH (WIDTH)
  ) u_bitwise_unit (
    .a   (a_arr[win_c]),
    .b   (b_arr[win_c]),
    .op  (op_e'(op_arr[win_c])),
    .y_c (y_c)
  );

  // Output stage: load on accept, drain on rsp_ready, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      rsp_data   <= '0;
      rsp_id     <= '0;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
      last_grant <= ID_W'(NUM_REQ - 1);
`endif
    end else if (accept_c) begin
      state      <= ST_FULL;
      rsp_data   <= y_c;
      rsp_id     <= win_c;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
      last_grant <= win_c;
`endif
    end else if (state == ST_FULL && rsp_ready) begin
      state      <= ST_EMPTY;
    end
  end

  assign rsp_valid = (state == ST_FULL);
  assign busy      = (state == ST_FULL);

endmodule
